// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate backed by a word-addressed SRAM, with programmable wait states and a two-cycle ERROR response.
// Build option: define AHB_SRAM_SUBORDINATE_PROT_CHECK_EN to reject unprivileged writes to the upper half of memory.
module ahb_sram_subordinate #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_ERR1, ST_ERR2} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      word_q, word_d;
    logic                  write_q, write_d;
    logic [NB-1:0]         mask_q, mask_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_word;
    logic [NB-1:0]         size_lanes, lane_mask;
    logic                  misaligned, too_wide, out_of_range, prot_err, err_flag;
    logic                  capture;
    logic                  unused_ok;

    assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0]};

    // Address-phase decode: word index, byte-lane mask and the error conditions.
    always_comb begin
        addr_word  = HADDR >> LSB;
        size_lanes = '0;
        misaligned = 1'b0;
        for (int i = 0; i < NB; i++)
            if (i < (1 << HSIZE)) size_lanes[i] = 1'b1;
        for (int i = 0; i < 8; i++)
            if (i < int'(HSIZE) && HADDR[i]) misaligned = 1'b1;
        lane_mask    = size_lanes << HADDR[LSB-1:0];
        too_wide     = (HSIZE > 3'(LSB));
        out_of_range = (addr_word >= ADDR_WIDTH'(MEM_DEPTH));
`ifdef AHB_SRAM_SUBORDINATE_PROT_CHECK_EN
        prot_err     = HWRITE && !HPROT[1] && (addr_word >= ADDR_WIDTH'(MEM_DEPTH / 2));
`else
        prot_err     = 1'b0;
`endif
        err_flag     = misaligned || too_wide || out_of_range || prot_err;
    end

    assign capture = (state_q inside {ST_IDLE, ST_ACCESS, ST_ERR2})
                     && HSEL && HREADY && HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            write_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            write_q <= write_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        write_d = write_q;
        mask_d  = mask_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_ACCESS;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, ACCESS and ERR2 all complete with HREADYOUT high and accept the next address phase.
                state_d = ST_IDLE;
                if (capture) begin
                    word_d  = addr_word[IDX_W-1:0];
                    write_d = HWRITE;
                    mask_d  = lane_mask;
                    if (err_flag) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
        endcase
    end

    // NOTE: the memory array has no reset; contents survive HRESET by design.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state_q == ST_ACCESS && write_q) begin
            for (int b = 0; b < NB; b++)
                if (mask_q[b] && HWSTRB[b]) mem[word_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state_q)
            ST_WAIT:   HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2:   HRESP = 1'b1;
            ST_ACCESS: if (!write_q) HRDATA = mem[word_q];
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed self-checking bench: one instance with zero wait states, one with three, sharing the bus stimulus.
module tb_ahb_sram_subordinate;
`ifdef AHB_SRAM_SUBORDINATE_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic [31:0] rdata0, rdata3, rdata_m;
    logic        ready0, ready3, ready_m;
    logic        resp0, resp3, resp_m;
    logic        use3;

    int vectors = 0;
    int miscompares = 0;

    ahb_sram_subordinate #(.WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ready0),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_sram_subordinate #(.WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(ready3),
        .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3)
    );

    assign rdata_m = use3 ? rdata3 : rdata0;
    assign ready_m = use3 ? ready3 : ready0;
    assign resp_m  = use3 ? resp3  : resp0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single non-pipelined transfer: address phase, then data phase with wait/error cycles counted.
    task automatic xfer(input bit on3, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] prot,
                        input bit exp_err, input logic [31:0] exp_rdata, input string tag);
        int waits;
        bit low_resp_ok;
        int exp_waits;
        exp_waits = exp_err ? 1 : (on3 ? 3 : 0);
        @(posedge clk); #1;
        use3 = on3; hsel0 = !on3; hsel3 = on3;
        haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size; hprot = prot;
        @(posedge clk); #1;
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwdata = wdata; hwstrb = strb;
        waits = 0;
        low_resp_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_m) break;
            waits++;
            if (resp_m !== exp_err) low_resp_ok = 1'b0;
            @(posedge clk); #1;
        end
        check({tag, "_waits"}, waits, exp_waits);
        if (waits > 0) check({tag, "_lowresp"}, low_resp_ok, 1);
        check({tag, "_ready"}, ready_m, 1);
        check({tag, "_resp"}, resp_m, exp_err);
        check({tag, "_rdata"}, rdata_m, (wr || exp_err) ? 32'h0 : exp_rdata);
    endtask

    initial begin
        rst = 1'b1; use3 = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hprot = 4'b0010; hmastlock = 1'b0;
        hwdata = '0; hwstrb = 4'hF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", ready0, 1);
        check("rst_resp0", resp0, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_ready3", ready3, 1);
        check("rst_resp3", resp3, 0);
        check("rst_rdata3", rdata3, 0);
        rst = 1'b0;

        // Pipelined write then read of the same word, zero wait states.
        @(posedge clk); #1;
        use3 = 1'b0; hsel0 = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; hwstrb = 4'hF; hwrite = 1'b0;
        @(negedge clk);
        check("b2b_wr_ready", ready_m, 1);
        check("b2b_wr_resp", resp_m, 0);
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("b2b_rd_ready", ready_m, 1);
        check("b2b_rd_resp", resp_m, 0);
        check("b2b_rd_rdata", rdata_m, 32'hDEADBEEF);

        xfer(0, 32'h11, 1, 3'd0, 32'h0000AB00, 4'hF, 4'b0010, 0, 32'h0, "byte_wr");
        xfer(0, 32'h10, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 0, 32'hDEADABEF, "byte_rd");
        xfer(0, 32'h10, 1, 3'd2, 32'h11223344, 4'b0101, 4'b0010, 0, 32'h0, "strb_wr");
        xfer(0, 32'h10, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 0, 32'hDE22AB44, "strb_rd");

        // Address phase with HSEL low must not be captured.
        @(posedge clk); #1;
        use3 = 1'b0; hsel0 = 1'b0; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        check("hsel_low_rdata", rdata_m, 0);
        check("hsel_low_ready", ready_m, 1);

        xfer(0, 32'h3FC, 1, 3'd2, 32'h0BADC0DE, 4'hF, 4'b0010, 0, 32'h0, "last_wr");
        xfer(0, 32'h3FC, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 0, 32'h0BADC0DE, "last_rd");
        xfer(0, 32'h400, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 1, 32'h0, "oor_rd");

        xfer(0, 32'h0, 1, 3'd2, 32'hCAFEF00D, 4'hF, 4'b0010, 0, 32'h0, "w0_wr");
        xfer(0, 32'h2, 1, 3'd2, 32'h12345678, 4'hF, 4'b0010, 1, 32'h0, "misalign_wr");
        xfer(0, 32'h0, 1, 3'd3, 32'h87654321, 4'hF, 4'b0010, 1, 32'h0, "toowide_wr");
        xfer(0, 32'h0, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 0, 32'hCAFEF00D, "w0_rd");

        xfer(0, 32'h300, 1, 3'd2, 32'hA5A5A5A5, 4'hF, 4'b0010, 0, 32'h0, "prot_init_wr");
        xfer(0, 32'h300, 1, 3'd2, 32'h5A5A5A5A, 4'hF, 4'b0000, PROT_EN, 32'h0, "prot_unpriv_wr");
        xfer(0, 32'h300, 0, 3'd2, 32'h0, 4'hF, 4'b0000, 0,
             PROT_EN ? 32'hA5A5A5A5 : 32'h5A5A5A5A, "prot_unpriv_rd");
        xfer(0, 32'h300, 1, 3'd2, 32'h3C3C3C3C, 4'hF, 4'b0010, 0, 32'h0, "prot_priv_wr");
        xfer(0, 32'h300, 0, 3'd2, 32'h0, 4'hF, 4'b0000, 0, 32'h3C3C3C3C, "prot_priv_rd");

        xfer(1, 32'h20, 1, 3'd2, 32'h600DF00D, 4'hF, 4'b0010, 0, 32'h0, "ws3_wr");
        xfer(1, 32'h20, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 0, 32'h600DF00D, "ws3_rd");
        xfer(1, 32'h400, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 1, 32'h0, "ws3_err_rd");
        xfer(1, 32'h30, 1, 3'd2, 32'h11112222, 4'hF, 4'b0010, 0, 32'h0, "ws3_w30");

        // Reset during the wait states of a write: the write must be abandoned.
        @(posedge clk); #1;
        use3 = 1'b1; hsel3 = 1'b1; haddr = 32'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel3 = 1'b0; htrans = 2'b00; hwdata = 32'h99999999; hwstrb = 4'hF;
        @(negedge clk);
        check("midrst_wait_ready", ready_m, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_ready", ready_m, 1);
        check("midrst_resp", resp_m, 0);
        check("midrst_rdata", rdata_m, 0);
        rst = 1'b0;
        xfer(1, 32'h30, 0, 3'd2, 32'h0, 4'hF, 4'b0010, 0, 32'h11112222, "midrst_rd");

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
